ddr3_stub_controller: RTL and testbench

- Behavioural stand-in for the DDR3 controller, on the responder side of the rd/wr/refresh/busy/data_ready interface.
- Backs the interface with an internal block-RAM word array and programmable per-command latencies.
- Lets initiators (memory testers, the NES memory arbiter) be brought up and verified on FPGA or in simulation without the real DDR3 PHY.
- Drop-in for the controller's user-side port list.

---
 rtl/ddr3_stub_controller.sv | 212 +++++++++++++++++++++
 tb/tb_ddr3_stub_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_stub_controller.sv
// ---------------------------------------------------------------------------
// ddr3_stub_controller
//
// Behavioural stand-in for the DDR3 controller, responder side of the
// rd/wr/refresh/busy/data_ready user interface. Commands are served from an
// internal block-RAM word array. Each command class holds busy for its own
// programmable number of cycles. Initiators such as memory testers and the
// NES memory arbiter can therefore be brought up without the DDR3 PHY.
//
// Parameters:
//   ADDR_WIDTH  - low address bits decoded; depth = 2**ADDR_WIDTH 16-bit words
//   WR_LATENCY  - cycles busy is held for a write   (>= 1)
//   RD_LATENCY  - cycles busy is held for a read    (>= 1)
//   REF_LATENCY - cycles busy is held for a refresh (>= 1)
//
// Ports:
//   clk          in   controller clock
//   resetn       in   asynchronous active-low reset
//   rd           in   read command pulse
//   wr           in   write command pulse (highest priority)
//   refresh      in   refresh command pulse (lowest priority)
//   addr[25:0]   in   word address, only addr[ADDR_WIDTH-1:0] decoded
//   din[15:0]    in   write data, sampled with wr
//   fault_inject in   [1:0], present only with DDR3_STUB_FAULT_EN
//   dout[15:0]   out  read data, updated when a read completes, then held
//   data_ready   out  one-cycle pulse marking a completed read
//   busy         out  command in progress; commands seen while high are dropped
//
// Build option:
//   DDR3_STUB_FAULT_EN - adds fault_inject. Bit1 flips dout[8] and bit0 flips
//                        dout[0] as read data is loaded, which lets testers
//                        exercise their high/low byte failure detection.
// ---------------------------------------------------------------------------
module ddr3_stub_controller #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WR_LATENCY  = 4,
    parameter int RD_LATENCY  = 6,
    parameter int REF_LATENCY = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd,
    input  logic        wr,
    input  logic        refresh,
    input  logic [25:0] addr,
    input  logic [15:0] din,
`ifdef DDR3_STUB_FAULT_EN
    input  logic [1:0]  fault_inject,
`endif
    output logic [15:0] dout,
    output logic        data_ready,
    output logic        busy
);

    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int MAX_LAT = max3(WR_LATENCY, RD_LATENCY, REF_LATENCY);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REF_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        REFRESH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   data_ready_q, data_ready_d;
    logic [DATA_W-1:0]      dout_q, dout_d;

    // Word captured from the array when a read is accepted. Because the read
    // happens at accept, any later write to the same address cannot change
    // the result of a read that is already in flight.
    logic [DATA_W-1:0]      rd_word_q;

    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]  addr_idx;
    logic                   acc_wr;
    logic                   acc_rd;
    logic                   mem_we;
    logic [DATA_W-1:0]      fault_mask;

    // Upper address bits are deliberately ignored (aliasing). They are folded
    // into a sink here so the port can stay full width.
    logic                   unused_addr;
    assign unused_addr = ^addr;

    assign addr_idx = addr[ADDR_WIDTH-1:0];

`ifdef DDR3_STUB_FAULT_EN
    assign fault_mask = {7'b0, fault_inject[1], 7'b0, fault_inject[0]};
`else
    assign fault_mask = '0;
`endif

    // ------------------------------------------------------------------
    // Next-state and command acceptance
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        data_ready_d = 1'b0;
        dout_d       = dout_q;
        acc_wr       = 1'b0;
        acc_rd       = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // Fixed priority wr > rd > refresh. Losers are simply dropped.
                if (wr) begin
                    acc_wr  = 1'b1;
                    state_d = WRITE;
                    cnt_d   = WR_LOAD;
                    busy_d  = 1'b1;
                end else if (rd) begin
                    acc_rd  = 1'b1;
                    state_d = READ;
                    cnt_d   = RD_LOAD;
                    busy_d  = 1'b1;
                end else if (refresh) begin
                    state_d = REFRESH;
                    cnt_d   = REF_LOAD;
                    busy_d  = 1'b1;
                end
            end

            WRITE, REFRESH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            READ: begin
                // The closing edge of the last busy cycle publishes the data.
                // data_ready and busy=0 then coincide for one cycle.
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    data_ready_d = 1'b1;
                    dout_d       = rd_word_q ^ fault_mask;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            data_ready_q <= data_ready_d;
            dout_q       <= dout_d;
        end
    end

    // ------------------------------------------------------------------
    // Word array and read capture (no reset, so the array maps to BRAM)
    // ------------------------------------------------------------------
    // During reset the FSM is already in IDLE. The write enable is therefore
    // qualified with resetn so that a wr held during reset cannot write the array.
    assign mem_we = acc_wr & resetn;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_idx] <= din;
        end
        if (acc_rd) begin
            rd_word_q <= mem_q[addr_idx];
        end
    end

    assign dout       = dout_q;
    assign data_ready = data_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ddr3_stub_controller.sv
module tb_ddr3_stub_controller;

    logic        clk;
    logic        resetn;
    logic        rd;
    logic        wr;
    logic        refresh;
    logic [25:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        data_ready;
    logic        busy;
`ifdef DDR3_STUB_FAULT_EN
    logic [1:0]  fault_inject;
`endif

    ddr3_stub_controller dut (
        .clk          (clk),
        .resetn       (resetn),
        .rd           (rd),
        .wr           (wr),
        .refresh      (refresh),
        .addr         (addr),
        .din          (din),
`ifdef DDR3_STUB_FAULT_EN
        .fault_inject (fault_inject),
`endif
        .dout         (dout),
        .data_ready   (data_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected read words, pushed when a read is issued, popped on data_ready.
    logic [15:0] sb[$];

    typedef struct {
        logic        w;
        logic        r;
        logic        f;
        logic [25:0] a;
        logic [15:0] d;
        int          busy_n;
        bit          dr;
        logic [15:0] dout_after;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock, then sample 1ns after the edge and service the scoreboard.
    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (data_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_data_ready: got dout %h expected no data_ready", dout);
            end else begin
                e = sb.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", dout, e);
                end
            end
        end
    endtask

    task automatic clear_cmd();
        wr = 1'b0;
        rd = 1'b0;
        refresh = 1'b0;
    endtask

    // Issue one command from the idle cycle, measure its busy length and the
    // dout value left behind once busy drops.
    task automatic run_cmd(input string nm, input logic w, input logic r, input logic f,
                           input logic [25:0] a, input logic [15:0] d,
                           input int exp_busy, input bit dr, input logic [15:0] exp_dout);
        int n;
        wr = w;
        rd = r;
        refresh = f;
        addr = a;
        din = d;
        if (dr) sb.push_back(exp_dout);
        tick();
        clear_cmd();
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        chk({nm, "_busy_len"}, n, exp_busy);
        chk({nm, "_dout"}, dout, exp_dout);
    endtask

    initial begin
        int n;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 26'd5,        16'h1234, 4, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 26'd5,        16'h0000, 6, 1'b1, 16'h1234};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 26'h400,      16'hAAAA, 4, 1'b0, 16'h1234};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 26'd0,        16'h0000, 6, 1'b1, 16'hAAAA};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 26'd5,        16'h0000, 6, 1'b1, 16'h1234};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 26'd7,        16'h5555, 4, 1'b0, 16'h1234};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 26'd7,        16'h0000, 6, 1'b1, 16'h5555};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 26'd7,        16'h0000, 8, 1'b0, 16'h5555};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 26'd5,        16'h0000, 6, 1'b1, 16'h1234};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 26'd3,        16'h0F0F, 4, 1'b0, 16'h1234};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 26'h3FF,      16'hBEEF, 4, 1'b0, 16'h1234};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 26'h3FFFFFF,  16'h0000, 6, 1'b1, 16'hBEEF};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 26'd20,       16'hC0DE, 4, 1'b0, 16'hBEEF};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 26'd20,       16'h0000, 6, 1'b1, 16'hC0DE};

        resetn = 1'b0;
        clear_cmd();
        addr = '0;
        din = '0;
`ifdef DDR3_STUB_FAULT_EN
        fault_inject = 2'b00;
`endif
        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_data_ready", data_ready, 1'b0);
        chk("reset_dout", dout, 16'h0000);
        resetn = 1'b1;
        tick();

        // Table: every command issued in the first idle cycle after the last.
        for (int i = 0; i < NV; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].a,
                    tbl[i].d, tbl[i].busy_n, tbl[i].dr, tbl[i].dout_after);
        end

        // Commands sampled while busy must be dropped.
        rd = 1'b1;
        addr = 26'd3;
        sb.push_back(16'h0F0F);
        tick();
        clear_cmd();
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            clear_cmd();
            if (n == 2) begin
                wr = 1'b1;
                addr = 26'd3;
                din = 16'hFFFF;
            end else if (n == 4) begin
                rd = 1'b1;
                refresh = 1'b1;
                addr = 26'd5;
            end
            tick();
        end
        clear_cmd();
        chk("drop_busy_len", n, 6);
        chk("drop_dout", dout, 16'h0F0F);
        run_cmd("drop_reread", 1'b0, 1'b1, 1'b0, 26'd3, 16'h0, 6, 1'b1, 16'h0F0F);

        // Reset in the third busy cycle of a read.
        rd = 1'b1;
        addr = 26'd5;
        tick();
        clear_cmd();
        chk("rst_pre_busy", busy, 1'b1);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_data_ready", data_ready, 1'b0);
        chk("rst_async_dout", dout, 16'h0000);
        tick();
        tick();
        resetn = 1'b1;
        repeat (10) tick();
        chk("rst_post_busy", busy, 1'b0);
        run_cmd("rst_mem5", 1'b0, 1'b1, 1'b0, 26'd5, 16'h0, 6, 1'b1, 16'h1234);
        run_cmd("rst_mem7", 1'b0, 1'b1, 1'b0, 26'd7, 16'h0, 6, 1'b1, 16'h5555);

`ifdef DDR3_STUB_FAULT_EN
        run_cmd("flt_wr", 1'b1, 1'b0, 1'b0, 26'd9, 16'h2B3C, 4, 1'b0, 16'h5555);
        fault_inject = 2'b10;
        run_cmd("flt_hi", 1'b0, 1'b1, 1'b0, 26'd9, 16'h0, 6, 1'b1, 16'h2A3C);
        fault_inject = 2'b01;
        run_cmd("flt_lo", 1'b0, 1'b1, 1'b0, 26'd9, 16'h0, 6, 1'b1, 16'h2B3D);
        fault_inject = 2'b00;
        run_cmd("flt_off", 1'b0, 1'b1, 1'b0, 26'd9, 16'h0, 6, 1'b1, 16'h2B3C);
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
